// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the fetch/load-store memory arbiter:
//   state_t : arbiter FSM state (IDLE -> ADDR -> WAIT -> IDLE)
//   owner_t : which side owns the transaction in flight
// Grant vectors are one-hot, bit GNT_INST = fetch, bit GNT_DATA = load/store.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam int GNT_INST = 0;
  localparam int GNT_DATA = 1;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin tie-break. A lone request always wins; when both sides
// request, the side that was not granted last wins.
// Ports:
//   i_req_inst   : fetch side requesting
//   i_req_data   : load/store side requesting
//   i_last_grant : owner of the most recent grant
//   o_grant      : one-hot grant, [GNT_INST] fetch, [GNT_DATA] load/store
// ---------------------------------------------------------------------------
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       i_req_inst,
  input  logic       i_req_data,
  input  owner_t     i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    o_grant = '0;
    if (i_req_inst && i_req_data) begin
      if (i_last_grant == OWN_INST) o_grant[GNT_DATA] = 1'b1;
      else                          o_grant[GNT_INST] = 1'b1;
    end else begin
      o_grant[GNT_INST] = i_req_inst;
      o_grant[GNT_DATA] = i_req_data;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between a read-only fetch side and a load/store
// side, with at most one transaction outstanding on the shared port.
//   IDLE : a winning request gets addr_ok this cycle; its fields are latched.
//   ADDR : mem_req is driven from the latched fields until mem_addr_ok.
//   WAIT : waits for mem_data_ok, which is forwarded to the owner's data_ok.
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   inst_req/addr, inst_addr_ok,
//   inst_data_ok, inst_rdata        : fetch side
//   data_req/wr/wstrb/addr/wdata,
//   data_addr_ok, data_data_ok,
//   data_rdata                      : load/store side
//   mem_req/wr/wstrb/addr/wdata,
//   mem_addr_ok, mem_data_ok,
//   mem_rdata                       : shared memory port
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,

  input  logic            data_req,
  input  logic            data_wr,
  input  logic [DW/8-1:0] data_wstrb,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic [DW-1:0]   data_rdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,

  output logic            mem_req,
  output logic            mem_wr,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_addr_ok,
  input  logic            mem_data_ok
);

  localparam int SW = DW / 8;

  state_t          r_state;
  state_t          w_next_state;
  owner_t          r_owner;
  owner_t          r_last_grant;
  logic [AW-1:0]   r_addr;
  logic            r_wr;
  logic [SW-1:0]   r_wstrb;
  logic [DW-1:0]   r_wdata;

  logic [1:0]      w_grant;
  logic            w_done;
  logic            w_take;

  rr_arb2 u_rr_arb2 (
    .i_req_inst   (inst_req),
    .i_req_data   (data_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_next_state = r_state;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    mem_req      = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Reset also masks the grant so addr_ok stays low while rst is held,
        // even though the requests themselves may be active.
        if (rst) begin
          inst_addr_ok = w_grant[GNT_INST];
          data_addr_ok = w_grant[GNT_DATA];
          if (|w_grant) w_next_state = ADDR;
        end
      end
      ADDR: begin
        mem_req = 1'b1;
        // A memory that answers in the accepting cycle skips WAIT entirely.
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            w_done       = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_data_ok) begin
          w_done       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_take = inst_addr_ok | data_addr_ok;

  // Request latch: captured on the grant, held through ADDR and WAIT.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the latched fields are reset too, so the shared port never shows
    // stale or X values after reset.
    if (!rst) begin
      r_owner      <= OWN_INST;
      r_last_grant <= OWN_INST;
      r_addr       <= '0;
      r_wr         <= 1'b0;
      r_wstrb      <= '0;
      r_wdata      <= '0;
    end else if (w_take) begin
      r_owner      <= data_addr_ok ? OWN_DATA : OWN_INST;
      r_last_grant <= data_addr_ok ? OWN_DATA : OWN_INST;
      r_addr       <= data_addr_ok ? data_addr : inst_addr;
      // The fetch side is read-only: its write controls are forced to zero.
      r_wr         <= data_addr_ok & data_wr;
      r_wstrb      <= data_addr_ok ? data_wstrb : '0;
      r_wdata      <= data_addr_ok ? data_wdata : '0;
    end
  end

  // Shared-port fields are only shown while a request is being presented.
  assign mem_wr    = mem_req & r_wr;
  assign mem_wstrb = mem_req ? r_wstrb : '0;
  assign mem_addr  = mem_req ? r_addr  : '0;
  assign mem_wdata = mem_req ? r_wdata : '0;

  assign inst_data_ok = w_done & (r_owner == OWN_INST);
  assign data_data_ok = w_done & (r_owner == OWN_DATA);

  // Read data is forwarded only in the owner's completion cycle.
  assign inst_rdata = inst_data_ok ? mem_rdata : '0;
  assign data_rdata = data_data_ok ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed stimulus for mem_arbiter. A transaction-level model (one slot:
// busy / address-accepted / owner / fields, plus the last granted side)
// predicts every output on every falling edge; directed sequences add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk;
  logic          rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic          data_req;
  logic          data_wr;
  logic [SW-1:0] data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] data_rdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic          mem_req;
  logic          mem_wr;
  logic [SW-1:0] mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_addr_ok;
  logic          mem_data_ok;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model: one transaction slot. Inputs change 1 ns after the
  // rising edge and stay put until the next one, so the model can predict the
  // outputs and advance to its post-edge state on the falling edge.
  // -------------------------------------------------------------------------
  logic          m_busy, m_acc, m_owner_data, m_last_data;
  logic [AW-1:0] m_addr;
  logic          m_wr;
  logic [SW-1:0] m_wstrb;
  logic [DW-1:0] m_wdata;
  logic          e_iaok, e_daok, e_idok, e_ddok, e_mreq, win_data, done;

  initial begin
    m_busy = 1'b0; m_acc = 1'b0; m_owner_data = 1'b0; m_last_data = 1'b0;
    m_addr = '0; m_wr = 1'b0; m_wstrb = '0; m_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst inst_addr_ok", inst_addr_ok, 0);
        check("rst data_addr_ok", data_addr_ok, 0);
        check("rst inst_data_ok", inst_data_ok, 0);
        check("rst data_data_ok", data_data_ok, 0);
        check("rst inst_rdata",   inst_rdata,   0);
        check("rst data_rdata",   data_rdata,   0);
        check("rst mem_req",      mem_req,      0);
        check("rst mem_wr",       mem_wr,       0);
        check("rst mem_wstrb",    mem_wstrb,    0);
        check("rst mem_addr",     mem_addr,     0);
        check("rst mem_wdata",    mem_wdata,    0);
        m_busy = 1'b0; m_acc = 1'b0; m_last_data = 1'b0;
      end else begin
        e_iaok = 1'b0; e_daok = 1'b0; e_idok = 1'b0; e_ddok = 1'b0;
        e_mreq = 1'b0; done = 1'b0; win_data = 1'b0;
        if (!m_busy) begin
          // Free slot: a lone request wins, a tie goes to the side not granted last.
          win_data = (inst_req && data_req) ? !m_last_data : data_req;
          if (inst_req || data_req) begin
            e_iaok = !win_data;
            e_daok = win_data;
          end
        end else if (!m_acc) begin
          e_mreq = 1'b1;
          done   = mem_addr_ok && mem_data_ok;
        end else begin
          done = mem_data_ok;
        end
        if (done) begin
          e_idok = !m_owner_data;
          e_ddok = m_owner_data;
        end

        check("inst_addr_ok", inst_addr_ok, e_iaok);
        check("data_addr_ok", data_addr_ok, e_daok);
        check("inst_data_ok", inst_data_ok, e_idok);
        check("data_data_ok", data_data_ok, e_ddok);
        check("mem_req",      mem_req,      e_mreq);
        if (e_mreq) begin
          check("mem_addr",  mem_addr,  m_addr);
          check("mem_wr",    mem_wr,    m_wr);
          check("mem_wstrb", mem_wstrb, m_wstrb);
          if (m_owner_data) check("mem_wdata", mem_wdata, m_wdata);
        end
        if (e_idok) check("inst_rdata", inst_rdata, mem_rdata);
        if (e_ddok) check("data_rdata", data_rdata, mem_rdata);

        // Advance the slot to what it holds after the coming rising edge.
        if (e_iaok || e_daok) begin
          m_busy       = 1'b1;
          m_acc        = 1'b0;
          m_owner_data = win_data;
          m_last_data  = win_data;
          m_addr       = win_data ? data_addr : inst_addr;
          m_wr         = win_data ? data_wr : 1'b0;
          m_wstrb      = win_data ? data_wstrb : '0;
          m_wdata      = data_wdata;
        end else if (done) begin
          m_busy = 1'b0;
        end else if (e_mreq && mem_addr_ok) begin
          m_acc = 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic quiet();
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with live inputs: everything must still read zero.
    rst = 1'b0;
    quiet();
    inst_req = 1'b1; data_req = 1'b1; mem_data_ok = 1'b1; mem_addr_ok = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    quiet();
    rst = 1'b1;
    tick();

    // Lone fetch, best-case latency.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    sample(); check("L039 c0 inst_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b1;
    sample(); check("L039 c1 mem_req", mem_req, 1);
              check("L039 c1 mem_addr", mem_addr, 32'hBFC0_0000);
              check("L039 c1 mem_wr", mem_wr, 0);
    tick();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h3C08_0001;
    sample(); check("L039 c2 inst_data_ok", inst_data_ok, 1);
              check("L039 c2 inst_rdata", inst_rdata, 32'h3C08_0001);
    tick();
    quiet();
    tick();

    // Simultaneous fetch and store after reset; store wins the first tie.
    // Re-apply reset so last_grant is back at its reset value.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h8000_0010; data_wdata = 32'h1234_ABCD;
    sample(); check("L040 c0 data_addr_ok", data_addr_ok, 1);
              check("L040 c0 inst_addr_ok", inst_addr_ok, 0);
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b1;
    sample(); check("L040 c1 mem_wr", mem_wr, 1);
              check("L040 c1 mem_wstrb", mem_wstrb, 4'b0011);
              check("L040 c1 mem_addr", mem_addr, 32'h8000_0010);
              check("L040 c1 mem_wdata", mem_wdata, 32'h1234_ABCD);
              check("L040 c1 inst_addr_ok busy", inst_addr_ok, 0);
    tick();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    sample(); check("L040 c2 data_data_ok", data_data_ok, 1);
              check("L040 c2 inst_addr_ok busy", inst_addr_ok, 0);
    tick();
    mem_data_ok = 1'b0;
    sample(); check("L040 c3 inst_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b1;
    sample(); check("L040 c4 fetch mem_wr", mem_wr, 0);
              check("L040 c4 fetch mem_wstrb", mem_wstrb, 0);
    tick();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0042;
    tick();
    quiet();

    // Both sides requesting continuously: grants alternate D,I,D,I,D,I
    // (the previous grant went to the fetch side).
    inst_req = 1'b1; inst_addr = 32'h0000_1000;
    data_req = 1'b1; data_addr = 32'h0000_2000; data_wr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      sample(); check("L041 data grant", data_addr_ok, (k % 2 == 0));
                check("L041 inst grant", inst_addr_ok, (k % 2 == 1));
      tick();
      mem_addr_ok = 1'b1;
      tick();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hA000_0000 + k;
      tick();
    end
    quiet();
    tick();

    // Memory stalls address acceptance 3 cycles; a stray mem_data_ok in ADDR
    // without mem_addr_ok is ignored.
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b1111;
    data_addr = 32'h8000_0020; data_wdata = 32'h55AA_55AA;
    tick();
    data_req = 1'b0; data_addr = '0; data_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      mem_data_ok = (k == 1);
      sample(); check("L042 stall mem_req", mem_req, 1);
                check("L042 stall mem_addr", mem_addr, 32'h8000_0020);
                check("L042 stall mem_wdata", mem_wdata, 32'h55AA_55AA);
                check("L042 stall data_data_ok", data_data_ok, 0);
      tick();
    end
    mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
    sample(); check("L042 accept data_data_ok", data_data_ok, 0);
    tick();
    mem_addr_ok = 1'b0;
    sample(); check("L042 wait data_data_ok", data_data_ok, 0);
    tick();
    mem_data_ok = 1'b1;
    sample(); check("L042 done data_data_ok", data_data_ok, 1);
    tick();
    quiet();

    // Address accept and response in the same ADDR cycle, then a stray
    // mem_data_ok while idle.
    inst_req = 1'b1; inst_addr = 32'h0000_0040;
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
    sample(); check("L043 same-cycle inst_data_ok", inst_data_ok, 1);
              check("L043 same-cycle inst_rdata", inst_rdata, 32'hCAFE_F00D);
    tick();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_DEAD;
    sample(); check("L043 stray inst_data_ok", inst_data_ok, 0);
              check("L043 stray data_data_ok", data_data_ok, 0);
              check("L043 stray mem_req", mem_req, 0);
    tick();
    quiet();

    // Reset during WAIT of a data transaction: no data_ok, and the first tie
    // after release still goes to data.
    data_req = 1'b1; data_addr = 32'h0000_0100;
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    sample(); check("L044 in WAIT mem_req", mem_req, 0);
    tick();
    rst = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222;
    inst_req = 1'b1; data_req = 1'b1;
    sample(); check("L044 rst data_data_ok", data_data_ok, 0);
              check("L044 rst data_addr_ok", data_addr_ok, 0);
    tick();
    rst = 1'b1; mem_data_ok = 1'b0;
    sample(); check("L044 first tie data_addr_ok", data_addr_ok, 1);
              check("L044 first tie inst_addr_ok", inst_addr_ok, 0);
    tick();
    data_req = 1'b0; inst_req = 1'b0; mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    tick();
    quiet();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width; wstrb width is DW/8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port inst_req  input  1  fetch read request (fetch side is read-only).
REQ-006 SHALL have port inst_addr  input  AW  fetch address.
REQ-007 SHALL have port inst_rdata  output  DW  fetch read data.
REQ-008 SHALL have port inst_addr_ok  output  1  fetch request accepted.
REQ-009 SHALL have port inst_data_ok  output  1  fetch data valid.
REQ-010 SHALL have port data_req  input  1  load/store request.
REQ-011 SHALL have port data_wr  input  1  1 = write.
REQ-012 SHALL have port data_wstrb  input  DW/8  byte enables.
REQ-013 SHALL have port data_addr  input  AW  load/store address.
REQ-014 SHALL have port data_wdata  input  DW  store data.
REQ-015 SHALL have port data_rdata  output  DW  load data.
REQ-016 SHALL have port data_addr_ok  output  1  load/store request accepted.
REQ-017 SHALL have port data_data_ok  output  1  load done or store acknowledged.
REQ-018 SHALL have port mem_req  output  1  shared-port request.
REQ-019 SHALL have port mem_wr  output  1  shared-port write.
REQ-020 SHALL have port mem_wstrb  output  DW/8  shared-port byte enables.
REQ-021 SHALL have port mem_addr  output  AW  shared-port address.
REQ-022 SHALL have port mem_wdata  output  DW  shared-port write data.
REQ-023 SHALL have port mem_rdata  input  DW  shared-port read data.
REQ-024 SHALL have port mem_addr_ok  input  1  shared-port request accepted.
REQ-025 SHALL have port mem_data_ok  input  1  shared-port response.

Function
REQ-026 SHALL implement FSM IDLE -> ADDR -> WAIT -> IDLE and allow at most one outstanding shared-port transaction.
REQ-027 In IDLE, a winning request SHALL get a combinational addr_ok pulse that same cycle, its fields SHALL be latched, its owner recorded, and the FSM SHALL go to ADDR.
REQ-028 Only one request SHALL win: a lone request wins; on a tie, the side not granted last wins; last_grant SHALL update on every grant.
REQ-029 In ADDR, mem_req SHALL be 1 and SHALL drive the latched fields; mem_wr and mem_wstrb SHALL be 0 for a fetch owner.
REQ-030 In ADDR, mem_addr_ok without mem_data_ok SHALL move the FSM to WAIT; without mem_addr_ok the FSM SHALL hold ADDR with fields stable.
REQ-031 On mem_data_ok in WAIT, or together with mem_addr_ok in ADDR, the owner's data_ok SHALL pulse that cycle and the FSM SHALL go to IDLE.
REQ-032 inst_rdata and data_rdata SHALL pass mem_rdata through combinationally, valid only while the matching data_ok is 1.
REQ-033 In ADDR and WAIT, no addr_ok SHALL be asserted; new requests wait, and the earliest re-grant is the cycle after completion (one bubble).
REQ-034 mem_data_ok while IDLE, or in ADDR without mem_addr_ok, SHALL be ignored with no state change.
REQ-035 Best-case latency SHALL be: req in cycle 0, mem_req in cycle 1, data_ok in cycle 2 when the memory responds in the cycle after accepting.

Reset
REQ-036 Reset SHALL force state=IDLE, last_grant=INST (so data wins the first tie), latched fields=0 and all outputs 0; reset mid-transaction SHALL abandon it with no data_ok.

Structure
REQ-037 Package mem_arb_pkg SHALL hold the state encoding (IDLE/ADDR/WAIT) and the owner codes (OWN_INST/OWN_DATA).
REQ-038 The 2-way tie-break SHALL be a sub-module rr_arb2 (inputs: two requests and last_grant; output: one-hot grant); the FSM and latches stay in mem_arbiter.

Verification
REQ-039 Lone fetch 0xBFC00000, memory acks the next cycle and returns 0x3C080001 one cycle later -> inst_addr_ok in cycle 0, mem_req in cycle 1, inst_data_ok with 0x3C080001 in cycle 2.
REQ-040 Simultaneous fetch and store (addr 0x80000010, wstrb 4'b0011, wdata 0x1234ABCD) after reset -> store granted first with mem_wr=1 and mem_wstrb=4'b0011, then fetch granted the cycle after the store's data_ok.
REQ-041 Both sides requesting continuously for 6 grants -> grants alternate D,I,D,I,D,I; no addr_ok while busy.
REQ-042 mem_addr_ok held low 3 cycles -> mem_req and the latched fields stay stable for 3 cycles; no data_ok until mem_data_ok.
REQ-043 mem_addr_ok and mem_data_ok in the same ADDR cycle -> owner data_ok that cycle and the FSM returns to IDLE; a stray mem_data_ok in IDLE -> no output change.
REQ-044 rst asserted during WAIT -> outputs 0 immediately, state IDLE, no data_ok; the first tie after release goes to data.
